// File: rtl/reg_bank_mp.sv
// Multi-port register bank: one write port, NUM_RD registered read ports with write-first bypass.
// Optional per-register busy scoreboard enabled by defining REG_BANK_SCOREBOARD_EN.
module reg_bank_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_valid,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [NUM_RD-1:0]          rd_busy
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic              wr_ok;

    // A write to r0 is dropped entirely when r0 is hardwired, so it neither lands nor bypasses.
    assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    // Whole-bank asynchronous clear forces flop storage rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

`ifdef REG_BANK_SCOREBOARD_EN
    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;
    logic             rsv_ok;

    assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

    // Clear applied before set: a reservation issued alongside a write wins.
    always_comb begin
        busy_next = busy_reg;
        if (wr_ok) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_next[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end
`else
    logic [DEPTH-1:0] busy_next;
    logic             unused_rsv;

    assign busy_next  = '0;
    assign unused_rsv = ^{rsv_en, rsv_addr};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] value;
            logic [DATA_W-1:0] data_reg;
            logic              valid_reg;
            logic              busy_q_reg;

            assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

            always_comb begin
                value = mem_reg[addr];
                if (wr_ok && (wr_addr == addr)) begin
                    value = wr_data;
                end
                if ((ZERO_REG != 0) && (addr == '0)) begin
                    value = '0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg   <= '0;
                    valid_reg  <= 1'b0;
                    busy_q_reg <= 1'b0;
                end else begin
                    valid_reg <= rd_en[gi];
                    if (rd_en[gi]) begin
                        data_reg   <= value;
                        busy_q_reg <= busy_next[addr];
                    end
                end
            end

            assign rd_data[gi*DATA_W +: DATA_W] = data_reg;
            assign rd_valid[gi]                 = valid_reg;
            assign rd_busy[gi]                  = busy_q_reg;
        end
    endgenerate

endmodule
